cram_read_slave: RTL

CRAM_READ_SLAVE -- requirements
Module: cram_read_slave

---
 rtl/cram_read_slave.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/cram_read_slave.sv
// CRAM read slave: AXI4-style read-only port onto a synchronous single-port
// word RAM, plus a side-band load port used to place the program image.
// Beat data is read one cycle ahead: the read for the next beat is issued on
// the handshake of the current one, so bursts stream at one beat per cycle.

package cram_pkg;
    localparam int CRAM_ADDR_W = 10;
endpackage

module cram_read_slave
    import cram_pkg::*;
#(
    parameter int ADDR_W    = CRAM_ADDR_W,
    parameter int MEM_WORDS = 2 ** (ADDR_W - 2)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              clear,
    // read address channel
    input  logic [3:0]        s_cram_arid,
    input  logic [31:0]       s_cram_araddr,
    input  logic [7:0]        s_cram_arlen,
    input  logic [2:0]        s_cram_arsize,
    input  logic [1:0]        s_cram_arburst,
    input  logic              s_cram_arlock,
    input  logic [3:0]        s_cram_arcache,
    input  logic [2:0]        s_cram_arprot,
    input  logic [3:0]        s_cram_arqos,
    input  logic              s_cram_arvalid,
    output logic              s_cram_arready,
    // read data channel
    output logic [3:0]        s_cram_rid,
    output logic [31:0]       s_cram_rdata,
    output logic [1:0]        s_cram_rresp,
    output logic              s_cram_rlast,
    output logic              s_cram_rvalid,
    input  logic              s_cram_rready,
    // program load port
    input  logic              ld_we,
    input  logic [ADDR_W-3:0] ld_addr,
    input  logic [31:0]       ld_data
);

    localparam logic [31:0] MEM_WORDS_U = 32'(MEM_WORDS);
    localparam logic [1:0]  BURST_INCR  = 2'b01;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t      state, state_nxt;

    logic        arready_c;
    logic        ar_hs;
    logic        r_hs;
    logic        last_hs;
    logic        beat_adv;
    logic        rd_en;
    logic        ld_ok;

    // Word address (byte address >> 2) of the beat currently presented.
    logic [29:0] cur_word;
    logic [29:0] nxt_word;
    logic [29:0] rd_word;
    logic [7:0]  len_q;
    logic [7:0]  beat_cnt;
    logic [1:0]  burst_q;
    logic        req_err_q;
    logic        rlast_q;
    logic [1:0]  rresp_q;
    logic [3:0]  rid_q;
    logic [31:0] mem_q;

    logic [31:0] mem [0:MEM_WORDS-1];

    // Attributes the slave accepts but has no use for, plus the byte offset.
    logic        unused_sigs;
    assign unused_sigs = ^{s_cram_arlock, s_cram_arcache, s_cram_arprot,
                           s_cram_arqos, s_cram_araddr[1:0],
                           rd_word[29:ADDR_W-2]};

    // Request-level error: only 32-bit beats and FIXED/INCR bursts are served.
    function automatic logic req_err(input logic [2:0] size, input logic [1:0] burst);
        return (size != 3'd2) || burst[1];
    endfunction

    // Beat-level error: the word lies beyond the end of the CRAM.
    function automatic logic addr_err(input logic [29:0] word);
        return 32'(word) >= MEM_WORDS_U;
    endfunction

    function automatic logic [1:0] resp_of(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

    // State register; reset abandons any burst in flight.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake decode. A new request is only taken when the
    // channel is free or is being freed by the final-beat handshake.
    always_comb begin
        state_nxt = state;
        arready_c = 1'b0;
        case (state)
            IDLE:    arready_c = 1'b1;
            BURST:   arready_c = s_cram_rready & rlast_q;
            default: arready_c = 1'b0;
        endcase
        if (!nrst || clear) begin
            arready_c = 1'b0;
        end
        ar_hs    = s_cram_arvalid & arready_c;
        r_hs     = (state == BURST) & s_cram_rready;
        last_hs  = r_hs & rlast_q;
        beat_adv = r_hs & ~rlast_q & ~clear;
        case (state)
            IDLE:    if (ar_hs) state_nxt = BURST;
            BURST:   if (last_hs && !ar_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clear) begin
            state_nxt = IDLE;
        end
    end

    // Address of the next beat and the word the RAM is asked for this cycle.
    always_comb begin
        nxt_word = (burst_q == BURST_INCR) ? cur_word + 30'd1 : cur_word;
        rd_word  = ar_hs ? s_cram_araddr[31:2] : nxt_word;
        rd_en    = ar_hs | beat_adv;
        ld_ok    = nrst & ld_we & (32'(ld_addr) < MEM_WORDS_U);
    end

    // Burst bookkeeping and the registered per-beat R-channel attributes.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            cur_word  <= '0;
            len_q     <= '0;
            burst_q   <= '0;
            req_err_q <= 1'b0;
            rid_q     <= '0;
            beat_cnt  <= '0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
        end else if (clear) begin
            beat_cnt  <= '0;
            rlast_q   <= 1'b0;
        end else if (ar_hs) begin
            cur_word  <= s_cram_araddr[31:2];
            len_q     <= s_cram_arlen;
            burst_q   <= s_cram_arburst;
            req_err_q <= req_err(s_cram_arsize, s_cram_arburst);
            rid_q     <= s_cram_arid;
            beat_cnt  <= '0;
            rlast_q   <= (s_cram_arlen == 8'd0);
            rresp_q   <= resp_of(req_err(s_cram_arsize, s_cram_arburst) |
                                 addr_err(s_cram_araddr[31:2]));
        end else if (beat_adv) begin
            cur_word  <= nxt_word;
            beat_cnt  <= beat_cnt + 8'd1;
            rlast_q   <= (8'(beat_cnt + 8'd1) == len_q);
            rresp_q   <= resp_of(req_err_q | addr_err(nxt_word));
        end else if (last_hs) begin
            rlast_q   <= 1'b0;
        end
    end

    // CRAM: read-first single-port RAM; the read register only moves when a
    // new beat is fetched, which keeps rdata stable across stalls.
    always_ff @(posedge clk) begin
        if (ld_ok) begin
            mem[ld_addr] <= ld_data;
        end
        if (!nrst) begin
            mem_q <= '0;
        end else if (rd_en) begin
            mem_q <= mem[rd_word[ADDR_W-3:0]];
        end
    end

    assign s_cram_arready = arready_c;
    assign s_cram_rvalid  = (state == BURST);
    assign s_cram_rid     = rid_q;
    assign s_cram_rlast   = rlast_q;
    assign s_cram_rresp   = rresp_q;
    assign s_cram_rdata   = rresp_q[1] ? 32'd0 : mem_q;

endmodule
